// File: rtl/watch_timekeeper.sv
// Time-of-day clock and stopwatch counters for the watch chip.
// Binary s/m/h fields, all outputs registered; BCD conversion happens downstream.
module watch_timekeeper #(
    parameter int HOUR_WRAP    = 24,
    parameter int SW_HOUR_WRAP = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seconds_clk,
    input  logic [2:0] state,
    input  logic       btn_inc,
    input  logic       btn_startstop,
    input  logic       btn_clr,
    output logic [5:0] current_s,
    output logic [5:0] current_m,
    output logic [5:0] current_h,
    output logic [5:0] stopwatch_s,
    output logic [5:0] stopwatch_m,
    output logic [5:0] stopwatch_h,
    output logic       second,
    output logic       sw_running,
    output logic       sw_ovf
);

    localparam logic [2:0] MODE_SET_H = 3'd1;
    localparam logic [2:0] MODE_SET_M = 3'd2;
    localparam logic [2:0] MODE_SW    = 3'd4;
    localparam logic [5:0] SM_MAX     = 6'd59;
    localparam logic [5:0] H_MAX      = 6'(HOUR_WRAP - 1);
    localparam logic [5:0] SW_H_MAX   = 6'(SW_HOUR_WRAP - 1);

    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_PAUSED} sw_state_e;

    sw_state_e  sw_state_q, sw_state_d;
    logic [5:0] cur_s_q, cur_s_d, cur_m_q, cur_m_d, cur_h_q, cur_h_d;
    logic [5:0] sw_s_q, sw_s_d, sw_m_q, sw_m_d, sw_h_q, sw_h_d;
    logic       second_q, second_d, sw_running_q, sw_running_d, sw_ovf_q, sw_ovf_d;
    logic       sw_ss, sw_clr;

    // Time of day: frozen while a field is being set, otherwise ripples on each tick.
    always_comb begin
        cur_s_d  = cur_s_q;
        cur_m_d  = cur_m_q;
        cur_h_d  = cur_h_q;
        second_d = second_q ^ seconds_clk;
        if (state == MODE_SET_H) begin
            if (btn_inc) cur_h_d = (cur_h_q == H_MAX) ? 6'd0 : cur_h_q + 6'd1;
            if (btn_clr) cur_s_d = 6'd0;
        end else if (state == MODE_SET_M) begin
            if (btn_inc) cur_m_d = (cur_m_q == SM_MAX) ? 6'd0 : cur_m_q + 6'd1;
            if (btn_clr) cur_s_d = 6'd0;
        end else if (seconds_clk) begin
            if (cur_s_q == SM_MAX) begin
                cur_s_d = 6'd0;
                if (cur_m_q == SM_MAX) begin
                    cur_m_d = 6'd0;
                    cur_h_d = (cur_h_q == H_MAX) ? 6'd0 : cur_h_q + 6'd1;
                end else begin
                    cur_m_d = cur_m_q + 6'd1;
                end
            end else begin
                cur_s_d = cur_s_q + 6'd1;
            end
        end
    end

    // Stopwatch FSM keeps running in any mode; its buttons only count in stopwatch mode.
    always_comb begin
        sw_state_d = sw_state_q;
        sw_s_d     = sw_s_q;
        sw_m_d     = sw_m_q;
        sw_h_d     = sw_h_q;
        sw_ovf_d   = sw_ovf_q;
        sw_ss      = (state == MODE_SW) && btn_startstop;
        sw_clr     = (state == MODE_SW) && btn_clr;
        case (sw_state_q)
            SW_IDLE: begin
                if (sw_ss) sw_state_d = SW_RUN;
            end
            SW_RUN: begin
                if (seconds_clk) begin
                    if (sw_s_q == SM_MAX) begin
                        sw_s_d = 6'd0;
                        if (sw_m_q == SM_MAX) begin
                            sw_m_d = 6'd0;
                            if (sw_h_q == SW_H_MAX) begin
                                sw_h_d   = 6'd0;
                                sw_ovf_d = 1'b1;
                            end else begin
                                sw_h_d = sw_h_q + 6'd1;
                            end
                        end else begin
                            sw_m_d = sw_m_q + 6'd1;
                        end
                    end else begin
                        sw_s_d = sw_s_q + 6'd1;
                    end
                end
                if (sw_ss) sw_state_d = SW_PAUSED;
            end
            SW_PAUSED: begin
                // Clear takes priority over a simultaneous resume.
                if (sw_clr) begin
                    sw_state_d = SW_IDLE;
                    sw_s_d     = 6'd0;
                    sw_m_d     = 6'd0;
                    sw_h_d     = 6'd0;
                    sw_ovf_d   = 1'b0;
                end else if (sw_ss) begin
                    sw_state_d = SW_RUN;
                end
            end
            default: sw_state_d = SW_IDLE;
        endcase
        sw_running_d = (sw_state_d == SW_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_state_q   <= SW_IDLE;
            cur_s_q      <= 6'd0;
            cur_m_q      <= 6'd0;
            cur_h_q      <= 6'd0;
            sw_s_q       <= 6'd0;
            sw_m_q       <= 6'd0;
            sw_h_q       <= 6'd0;
            second_q     <= 1'b0;
            sw_running_q <= 1'b0;
            sw_ovf_q     <= 1'b0;
        end else begin
            sw_state_q   <= sw_state_d;
            cur_s_q      <= cur_s_d;
            cur_m_q      <= cur_m_d;
            cur_h_q      <= cur_h_d;
            sw_s_q       <= sw_s_d;
            sw_m_q       <= sw_m_d;
            sw_h_q       <= sw_h_d;
            second_q     <= second_d;
            sw_running_q <= sw_running_d;
            sw_ovf_q     <= sw_ovf_d;
        end
    end

    assign current_s   = cur_s_q;
    assign current_m   = cur_m_q;
    assign current_h   = cur_h_q;
    assign stopwatch_s = sw_s_q;
    assign stopwatch_m = sw_m_q;
    assign stopwatch_h = sw_h_q;
    assign second      = second_q;
    assign sw_running  = sw_running_q;
    assign sw_ovf      = sw_ovf_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Scoreboard bench for watch_timekeeper: a seconds-count reference model feeds an
// expected-value queue, a negedge monitor pops and compares every cycle.
module tb_watch_timekeeper;

    localparam int HW  = 24;
    localparam int SWH = 2;   // short stopwatch hour wrap so overflow is reachable quickly

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       seconds_clk = 1'b0, btn_inc = 1'b0, btn_startstop = 1'b0, btn_clr = 1'b0;
    logic [2:0] state = 3'd0;
    logic [5:0] current_s, current_m, current_h, stopwatch_s, stopwatch_m, stopwatch_h;
    logic       second, sw_running, sw_ovf;

    always #5 clk = ~clk;

    watch_timekeeper #(.HOUR_WRAP(HW), .SW_HOUR_WRAP(SWH)) dut (
        .clk(clk), .rst_n(rst_n), .seconds_clk(seconds_clk), .state(state),
        .btn_inc(btn_inc), .btn_startstop(btn_startstop), .btn_clr(btn_clr),
        .current_s(current_s), .current_m(current_m), .current_h(current_h),
        .stopwatch_s(stopwatch_s), .stopwatch_m(stopwatch_m), .stopwatch_h(stopwatch_h),
        .second(second), .sw_running(sw_running), .sw_ovf(sw_ovf)
    );

    typedef struct packed {
        logic [5:0] ch, cm, cs, sh, sm, ss;
        logic       sec, run, ovf;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    n_tests = 0, n_fail = 0;

    // Reference model: time of day and stopwatch held as plain second counts.
    int tod = 0, sw = 0, sw_mode = 0;   // sw_mode: 0 idle, 1 run, 2 paused
    bit sec_m = 0, ovf_m = 0;

    function automatic snap_t model_snap();
        snap_t r;
        r.ch  = 6'(tod / 3600);
        r.cm  = 6'((tod / 60) % 60);
        r.cs  = 6'(tod % 60);
        r.sh  = 6'(sw / 3600);
        r.sm  = 6'((sw / 60) % 60);
        r.ss  = 6'(sw % 60);
        r.sec = sec_m;
        r.run = (sw_mode == 1);
        r.ovf = ovf_m;
        return r;
    endfunction

    function automatic snap_t dut_snap();
        return {current_h, current_m, current_s, stopwatch_h, stopwatch_m, stopwatch_s,
                second, sw_running, sw_ovf};
    endfunction

    function automatic string fmt(snap_t v);
        return $sformatf("tod %0d:%0d:%0d sw %0d:%0d:%0d second=%0b run=%0b ovf=%0b",
                         v.ch, v.cm, v.cs, v.sh, v.sm, v.ss, v.sec, v.run, v.ovf);
    endfunction

    task automatic check(input string nm, input snap_t act, input snap_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got [%s] expected [%s]", nm, fmt(act), fmt(exp));
        end
    endtask

    task automatic model_step(input int st, input bit tk, inc, ss, clr);
        int h, m, s;
        bool_dummy();
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        if (tk) sec_m = ~sec_m;
        if (st == 1) begin
            if (inc) h = (h + 1) % HW;
            if (clr) s = 0;
            tod = h * 3600 + m * 60 + s;
        end else if (st == 2) begin
            if (inc) m = (m + 1) % 60;
            if (clr) s = 0;
            tod = h * 3600 + m * 60 + s;
        end else if (tk) begin
            tod = (tod + 1) % (HW * 3600);
        end
        if (st == 4 || sw_mode == 1) begin
            case (sw_mode)
                0: if (st == 4 && ss) sw_mode = 1;
                1: begin
                    if (tk) begin
                        sw = (sw + 1) % (SWH * 3600);
                        if (sw == 0) ovf_m = 1;
                    end
                    if (st == 4 && ss) sw_mode = 2;
                end
                default: begin
                    if (clr) begin sw_mode = 0; sw = 0; ovf_m = 0; end
                    else if (ss) sw_mode = 1;
                end
            endcase
        end
    endtask

    function automatic void bool_dummy();
    endfunction

    string phase = "reset";

    task automatic drive(input int st, input bit tk, inc, ss, clr);
        state = 3'(st); seconds_clk = tk; btn_inc = inc; btn_startstop = ss; btn_clr = clr;
        @(posedge clk); #1;
        model_step(st, tk, inc, ss, clr);
        exp_q.push_back(model_snap());
        name_q.push_back(phase);
        seconds_clk = 0; btn_inc = 0; btn_startstop = 0; btn_clr = 0;
    endtask

    task automatic idle_cycles(input int n, input int st);
        repeat (n) drive(st, 0, 0, 0, 0);
    endtask

    task automatic sw_to_idle();
        if (sw_mode == 1) drive(4, 0, 0, 1, 0);
        if (sw_mode == 2) drive(4, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle after an issued stimulus, compare DUT outputs to the model.
    initial begin
        snap_t e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, dut_snap(), e);
            end
        end
    end

    initial begin
        int r;
        int clock_modes[6] = '{0, 3, 5, 6, 7, 4};
        #12;
        check("reset_state", dut_snap(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "random_a";
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive($urandom_range(0, 7), r[1:0] == 0, r[4:2] == 0, r[7:5] == 0, r[10:8] == 0);
        end

        phase = "set_hour_wrap";
        while (tod / 3600 != HW - 1) drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);                  // 23 -> 0, m/s untouched
        while (tod / 3600 != HW - 1) drive(1, 1, 1, 0, 0);
        phase = "set_min_frozen";
        repeat (5) drive(2, 1, 0, 0, 0);       // ticks ignored while setting
        while ((tod / 60) % 60 != 59) drive(2, $urandom_range(0, 1), 1, 0, 0);
        drive(2, 0, 0, 0, 1);                  // clear seconds
        phase = "tod_ripple_wrap";
        repeat (58) begin
            drive(0, 1, 0, 0, 0);
            idle_cycles($urandom_range(0, 2), 0);
        end
        drive(0, 1, 0, 0, 0);                  // 23:59:59
        drive(3, 1, 0, 0, 0);                  // 00:00:00 in one tick

        phase = "sw_start_pause";
        sw_to_idle();
        drive(4, 1, 0, 1, 0);                  // tick on start edge not counted
        repeat (75) drive(4, 1, 0, 0, 0);
        drive(4, 1, 0, 0, 1);                  // clear ignored while running
        drive(4, 1, 0, 1, 0);                  // tick counted, then pause
        repeat (3) drive(4, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);                  // clear outside stopwatch mode ignored
        drive(4, 1, 0, 1, 1);                  // clear beats resume
        idle_cycles(2, 4);

        phase = "sw_overflow";
        drive(4, 0, 0, 1, 0);
        for (int i = 0; i < SWH * 3600 - 1; i++) drive(clock_modes[$urandom_range(0, 5)], 1, 0, 0, 0);
        drive(4, 1, 0, 0, 0);                  // wrap sets sticky overflow
        repeat (20) drive(0, 1, 0, 0, 0);
        drive(4, 0, 0, 1, 0);
        drive(4, 1, 0, 1, 0);                  // resume from pause, tick not counted
        drive(4, 0, 0, 1, 0);
        drive(4, 0, 0, 0, 1);                  // clears overflow

        phase = "midcount";
        drive(4, 0, 0, 1, 0);
        repeat (30) drive(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        exp_q.delete(); name_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_snap(), '0);
        tod = 0; sw = 0; sw_mode = 0; sec_m = 0; ovf_m = 0;
        @(posedge clk); #1;
        check("reset_held", dut_snap(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "random_b";
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            drive($urandom_range(0, 7), r[0], r[3:1] == 0, r[6:4] == 0, r[9:7] == 0);
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time bound");
        $fatal(1, "timeout");
    end

endmodule
